// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the two-source UART transmit arbiter.
// Build option: UART_ARB_CKSUM_EN adds the CKSUM state (XOR checksum byte per packet).
package uart_arb_pkg;

  localparam int NUM_SRC             = 2;
  localparam int DEFAULT_TIMEOUT_CYC = 1023;

`ifdef UART_ARB_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    CKSUM,
    FINISH
  } arb_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } arb_state_e;
`endif

  // Round-robin pick between the two sources: a lone request wins outright,
  // simultaneous requests go to the source that was not granted last.
  function automatic logic pickSource(input logic [NUM_SRC-1:0] reqVec, input logic lastSrc);
    if (reqVec == 2'b11) begin
      return ~lastSrc;
    end
    return reqVec[1];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_handshake.sv
// uart_tx_handshake: watches the UART busy line for the arbiter FSM.
// Reports a completed byte on the busy falling edge and a timeout when busy never rises.
module uart_tx_handshake
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_busy_i,
  input  logic wait_done_i,
  input  logic tx_busy_i,
  output logic byte_done_o,
  output logic timeout_o
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] toCnt_q;
  logic [CNT_W-1:0] toCnt_d;
  logic             busyPrev_q;
  logic             counting;

  assign counting    = wait_busy_i && !tx_busy_i;
  assign timeout_o   = counting && (toCnt_q == CNT_LAST);
  assign byte_done_o = wait_done_i && busyPrev_q && !tx_busy_i;

  // Count cycles spent waiting for busy to rise; any other cycle restarts the count.
  always_comb begin
    toCnt_d = '0;
    if (counting) begin
      toCnt_d = toCnt_q + CNT_W'(1);
    end
  end

  // Timeout counter and one-cycle history of busy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt_q    <= '0;
      busyPrev_q <= 1'b0;
    end else begin
      toCnt_q    <= toCnt_d;
      busyPrev_q <= tx_busy_i;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of two packet sources, streams its bytes to a UART
// transmitter with a busy handshake, and pulses done per packet.
// Build option: define UART_ARB_CKSUM_EN to append the XOR of all packet bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int LEN_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [LEN_W-1:0]   len0,
  input  logic [LEN_W-1:0]   len1,
  output logic [NUM_SRC-1:0] rd_en,
  input  logic [7:0]         rd_data0,
  input  logic [7:0]         rd_data1,
  output logic [NUM_SRC-1:0] grant,
  output logic [NUM_SRC-1:0] done,
  input  logic               tx_busy,
  output logic [7:0]         write_data,
  output logic               write_en,
  output logic               timeout_err
);

  arb_state_e         state_q, state_d, afterByte;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] done_q, done_d;
  logic               writeEn_q, writeEn_d;
  logic               timeoutErr_q, timeoutErr_d;
  logic [7:0]         writeData_q, writeData_d;
  logic [LEN_W-1:0]   byteCnt_q, byteCnt_d;
  logic               lastGrant_q, lastGrant_d;
  logic [7:0]         byteSrc;
  logic               winner;
  logic               byteDone;
  logic               busyTimeout;
  logic               waitBusy;
  logic               waitDone;
`ifdef UART_ARB_CKSUM_EN
  logic [7:0]         cksum_q, cksum_d;
  logic               cksumSent_q, cksumSent_d;
`endif

  assign waitBusy    = (state_q == WAIT_BUSY);
  assign waitDone    = (state_q == WAIT_DONE);
  assign byteSrc     = grant_q[1] ? rd_data1 : rd_data0;
  assign rd_en       = ((state_q == FETCH) && (byteCnt_q != '0)) ? grant_q : '0;
  assign grant       = grant_q;
  assign done        = done_q;
  assign write_en    = writeEn_q;
  assign write_data  = writeData_q;
  assign timeout_err = timeoutErr_q;

  uart_tx_handshake #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_handshake (
    .clk         (clk),
    .reset       (reset),
    .wait_busy_i (waitBusy),
    .wait_done_i (waitDone),
    .tx_busy_i   (tx_busy),
    .byte_done_o (byteDone),
    .timeout_o   (busyTimeout)
  );

  // Where to go once a byte has finished (or timed out): more data, checksum, or wrap up.
  always_comb begin
    afterByte = FINISH;
    if (byteCnt_q != '0) begin
      afterByte = FETCH;
    end
`ifdef UART_ARB_CKSUM_EN
    else if (!cksumSent_q) begin
      afterByte = CKSUM;
    end
`endif
  end

  // Next-state and registered-output decode for the packet FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    writeEn_d    = 1'b0;
    timeoutErr_d = 1'b0;
    writeData_d  = writeData_q;
    byteCnt_d    = byteCnt_q;
    lastGrant_d  = lastGrant_q;
    winner       = 1'b0;
`ifdef UART_ARB_CKSUM_EN
    cksum_d      = cksum_q;
    cksumSent_d  = cksumSent_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          winner    = pickSource(req, lastGrant_q);
          grant_d   = winner ? 2'b10 : 2'b01;
          byteCnt_d = winner ? len1 : len0;
`ifdef UART_ARB_CKSUM_EN
          cksum_d     = '0;
          cksumSent_d = 1'b0;
`endif
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = (byteCnt_q == '0) ? FINISH : LOAD;
      end
      LOAD: begin
        writeData_d = byteSrc;
        writeEn_d   = 1'b1;
        byteCnt_d   = byteCnt_q - LEN_W'(1);
`ifdef UART_ARB_CKSUM_EN
        cksum_d     = cksum_q ^ byteSrc;
`endif
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (busyTimeout) begin
          timeoutErr_d = 1'b1;
          state_d      = afterByte;
        end
      end
      WAIT_DONE: begin
        if (byteDone) begin
          state_d = afterByte;
        end
      end
`ifdef UART_ARB_CKSUM_EN
      CKSUM: begin
        writeData_d = cksum_q;
        writeEn_d   = 1'b1;
        cksumSent_d = 1'b1;
        state_d     = WAIT_BUSY;
      end
`endif
      FINISH: begin
        done_d      = grant_q;
        grant_d     = '0;
        lastGrant_d = grant_q[1];
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      writeEn_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      writeData_q  <= '0;
      byteCnt_q    <= '0;
      lastGrant_q  <= 1'b1;
`ifdef UART_ARB_CKSUM_EN
      cksum_q      <= '0;
      cksumSent_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      writeEn_q    <= writeEn_d;
      timeoutErr_q <= timeoutErr_d;
      writeData_q  <= writeData_d;
      byteCnt_q    <= byteCnt_d;
      lastGrant_q  <= lastGrant_d;
`ifdef UART_ARB_CKSUM_EN
      cksum_q      <= cksum_d;
      cksumSent_q  <= cksumSent_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, max cycles to wait for tx_busy to rise after a write_en pulse.
REQ-002 SHALL have parameter LEN_W, default 8, width of packet length inputs.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req  input  2  per-source packet request; held until the matching done pulse.
REQ-006 SHALL have port len0 / len1  input  LEN_W  packet byte count per source; sampled at grant.
REQ-007 SHALL have port rd_en  output  2  one-hot byte-fetch strobe to the granted source.
REQ-008 SHALL have port rd_data0 / rd_data1  input  8  source byte; valid the cycle after rd_en.
REQ-009 SHALL have port grant  output  2  one-hot; held for the whole packet.
REQ-010 SHALL have port done  output  2  one-cycle pulse at packet end.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port write_data  output  8  byte to the UART transmitter.
REQ-013 SHALL have port write_en  output  1  one-cycle byte-load strobe.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse when tx_busy fails to rise.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, WAIT_BUSY, WAIT_DONE, CKSUM, FINISH.
REQ-016 IDLE: if any req, grant one source, latch its len, load byte counter, clear checksum, go to FETCH the next cycle.
REQ-017 Arbitration: single request wins; on simultaneous requests, grant the source not granted last; last-grant resets to source 1, so source 0 wins first.
REQ-018 A latched len of 0 SHALL skip all bytes and go directly to FINISH.
REQ-019 FETCH: assert rd_en for exactly one cycle, then go to LOAD.
REQ-020 LOAD: register write_data <= rd_data of the granted source, pulse write_en in the following cycle, XOR the byte into checksum, decrement the counter, and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; after TIMEOUT_CYC cycles without it, pulse timeout_err and proceed as if the byte completed.
REQ-022 WAIT_DONE: on the tx_busy falling edge (previous 1, current 0), go to FETCH if bytes remain, otherwise to CKSUM/FINISH.
REQ-023 FINISH: pulse done for the granted source, clear grant, update last-grant, and return to IDLE.
REQ-024 write_en SHALL never be issued while tx_busy=1 or while the FSM is in WAIT_BUSY or WAIT_DONE.
REQ-025 Deasserting req mid-packet SHALL be ignored; the packet completes.
REQ-026 A req still held after done SHALL re-arbitrate in IDLE, with round-robin applying.
REQ-027 The byte counter SHALL be LEN_W bits wide; a len of 2^LEN_W-1 SHALL be supported without wrap.

Reset
REQ-028 Reset SHALL force IDLE and set grant, rd_en, done, write_en, timeout_err and write_data to 0, clear last-grant to source 1, and clear checksum, counter and timeout counter.
REQ-029 Reset mid-packet SHALL abort the packet with no done pulse and no further write_en.

Configuration
REQ-030 With macro UART_ARB_CKSUM_EN defined, after the last data byte the FSM SHALL enter CKSUM and send the XOR of all packet bytes as one extra byte, using the same write_en/busy handshake and timeout.
REQ-031 With UART_ARB_CKSUM_EN undefined, the CKSUM state, the checksum register and the extra byte SHALL be absent, and WAIT_DONE SHALL go directly to FINISH.
REQ-032 For len=0 with checksum enabled, no checksum byte SHALL be sent.

Structure
REQ-033 Package uart_arb_pkg SHALL hold the FSM state typedef, NUM_SRC=2 and the default TIMEOUT_CYC.
REQ-034 Sub-module uart_tx_handshake SHALL contain the tx_busy edge detection and the timeout counter, and report byte_done and timeout to the FSM.

Verification
REQ-035 Bench SHALL drive req=01, len0=3, bytes A1 A2 A3, with a UART model at busy 1 cycle after write_en for 10 cycles; required: three write_en pulses with A1,A2,A3 in order, one done[0] pulse, and grant=01 throughout.
REQ-036 Bench SHALL drive req=11 held, len0=len1=1; required grant order 01, 10, 01 and no overlapping grants.
REQ-037 Bench SHALL tie tx_busy to 0 with TIMEOUT_CYC=15 and send 1 byte; required: timeout_err pulses 15 cycles after write_en, then done[0].
REQ-038 Bench SHALL set len1=0 with req=10; required: no write_en, and done[1] 3 cycles after req.
REQ-039 With UART_ARB_CKSUM_EN defined, bench SHALL send 3C 0F; required: a third byte 33 follows.
REQ-040 Bench SHALL assert reset during WAIT_DONE of byte 2 of 4; required: next-cycle outputs all 0, no done, and a fresh packet after reset starts from byte 1.
